// File: rtl/div_iter_pkg.sv
// Shared types for the iterative divider: datapath words, decoded ops and FSM states.
package div_iter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [63:0] dword_t;

  typedef enum logic [3:0] {NOP, ADD, SUB, MULT, MULTU, DIV, DIVU} decoded_op_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  localparam int unsigned DivSteps = 32;

  function automatic word_t abs_w(input word_t x);
    return x[31] ? -x : x;
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Execute-stage to divider handshake: operands, op, en/flush request and hi/lo/finish result.
interface div_iter_if;

  div_iter_pkg::word_t       a;
  div_iter_pkg::word_t       b;
  div_iter_pkg::decoded_op_t op;
  logic                      en;
  logic                      flush;
  div_iter_pkg::word_t       hi;
  div_iter_pkg::word_t       lo;
  logic                      finish;

  modport master (output a, b, op, en, flush, input hi, lo, finish);
  modport slave  (input a, b, op, en, flush, output hi, lo, finish);

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on a {remainder, quotient} pair.
module div_step import div_iter_pkg::*; (
  input  word_t i_rem,
  input  word_t i_quo,
  input  word_t i_divisor,
  output word_t o_rem,
  output word_t o_quo
);

  logic [32:0] w_shift;
  logic [33:0] w_trial;

  assign w_shift = {i_rem, i_quo[31]};
  assign w_trial = {1'b0, w_shift} - {2'b00, i_divisor};

  // A kept (non-subtracted) shift is below the divisor, so it always fits in 32 bits.
  assign o_rem = w_trial[33] ? w_shift[31:0] : w_trial[31:0];
  assign o_quo = {i_quo[30:0], ~w_trial[33]};

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for DIV/DIVU: remainder to hi, quotient to lo, finish strobe.
module div_iter import div_iter_pkg::*; #(
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input logic       clk,
  input logic       reset,
  div_iter_if.slave bus
);

  localparam logic [5:0] StepInc = 6'(STEPS_PER_CYCLE);
  localparam logic [5:0] DoneCnt = 6'(DivSteps);

  div_state_t r_state;
  logic [5:0] r_cnt;
  word_t      r_rem;
  word_t      r_quo;
  word_t      r_divisor;
  logic       r_neg_q;
  logic       r_neg_r;
  logic       r_div0;
  word_t      r_hi;
  word_t      r_lo;
  logic       r_finish;

  word_t w_rem [STEPS_PER_CYCLE+1];
  word_t w_quo [STEPS_PER_CYCLE+1];
  logic  w_start;
  logic  w_signed;

  assign w_signed = (bus.op == DIV);
  assign w_start  = bus.en & ~bus.flush & ((bus.op == DIV) | (bus.op == DIVU));

  assign w_rem[0] = r_rem;
  assign w_quo[0] = r_quo;

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    div_step u_step (
      .i_rem     (w_rem[g]),
      .i_quo     (w_quo[g]),
      .i_divisor (r_divisor),
      .o_rem     (w_rem[g+1]),
      .o_quo     (w_quo[g+1])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_finish  <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_quo     <= w_signed ? abs_w(bus.a) : bus.a;
            r_divisor <= w_signed ? abs_w(bus.b) : bus.b;
            r_neg_q   <= w_signed & (bus.a[31] ^ bus.b[31]);
            r_neg_r   <= w_signed & bus.a[31];
            r_div0    <= (bus.b == '0);
            r_rem     <= '0;
            r_cnt     <= '0;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          if (bus.flush) begin
            r_state <= IDLE;
          end else if (r_cnt == DoneCnt) begin
            // With b=0 every trial succeeds, so rem ends as |a| and the fix-up restores a.
            r_hi     <= r_neg_r ? -r_rem : r_rem;
            r_lo     <= r_div0 ? '1 : (r_neg_q ? -r_quo : r_quo);
            r_finish <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_rem <= w_rem[STEPS_PER_CYCLE];
            r_quo <= w_quo[STEPS_PER_CYCLE];
            r_cnt <= r_cnt + StepInc;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.hi     = r_hi;
  assign bus.lo     = r_lo;
  assign bus.finish = r_finish;

endmodule
